// File: rtl/stack_pkg.sv
// Shared types and width helpers for the banked stack.
package stack_pkg;

  typedef enum logic [1:0] {
    NOP     = 2'd0,
    PUSH    = 2'd1,
    POP     = 2'd2,
    REPLACE = 2'd3
  } stack_op_t;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int sel_width(input int num_stacks);
    return (num_stacks > 1) ? $clog2(num_stacks) : 1;
  endfunction

endpackage

// File: rtl/stack_mem.sv
// Flat storage for all stacks: one synchronous write port, one asynchronous read port.
module stack_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ENTRIES    = 128,
  parameter int AW         = 7
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [ENTRIES];

  // NOTE: storage has no reset; the stack counts alone decide which entries are live.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/banked_stack.sv
// NUM_STACKS independent LIFO stacks sharing one memory, one command per cycle.
module banked_stack
  import stack_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int NUM_STACKS = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [sel_width(NUM_STACKS)-1:0]    stack_sel,
  input  logic [DATA_WIDTH-1:0]               inp_data,
  input  logic                                push,
  input  logic                                pop,
  input  logic                                flush,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic                                out_valid,
  output logic [NUM_STACKS-1:0]               stack_empty,
  output logic [NUM_STACKS-1:0]               stack_full,
  output logic [count_width(DEPTH)-1:0]       sel_count,
  output logic                                overflow,
  output logic                                underflow,
  output logic                                bad_sel
);

  localparam int SW      = sel_width(NUM_STACKS);
  localparam int CW      = count_width(DEPTH);
  localparam int ENTRIES = NUM_STACKS * DEPTH;
  localparam int AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [CW-1:0]         cnt_q [NUM_STACKS];
  logic [CW-1:0]         cnt_d [NUM_STACKS];
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  bad_q, bad_d;

  logic                  sel_valid;
  logic [SW-1:0]         sel_idx;
  logic [CW-1:0]         cur_cnt;
  logic                  cur_empty, cur_full;
  stack_op_t             op;

  logic                  wr_en;
  logic [AW-1:0]         base_addr, wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  // Out-of-range selects are clamped to stack 0 so no array read goes out of bounds.
  assign sel_valid = 32'(stack_sel) < 32'(NUM_STACKS);
  assign sel_idx   = sel_valid ? stack_sel : '0;
  assign cur_cnt   = sel_valid ? cnt_q[sel_idx] : '0;
  assign cur_empty = (cur_cnt == '0);
  assign cur_full  = (cur_cnt == CW'(DEPTH));
  assign sel_count = cur_cnt;

  assign base_addr = AW'(sel_idx) * AW'(DEPTH);
  assign rd_addr   = base_addr + AW'(cur_cnt - CW'(1));

  always_comb begin
    case ({push, pop})
      2'b10:   op = PUSH;
      2'b01:   op = POP;
      2'b11:   op = REPLACE;
      default: op = NOP;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_STACKS; i++) begin
      stack_empty[i] = (cnt_q[i] == '0);
      stack_full[i]  = (cnt_q[i] == CW'(DEPTH));
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    valid_d    = 1'b0;
    ovf_d      = 1'b0;
    unf_d      = 1'b0;
    bad_d      = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = base_addr + AW'(cur_cnt);

    if (!sel_valid) begin
      bad_d = flush || (op != NOP);
    end else if (flush) begin
      cnt_d[sel_idx] = '0;
    end else begin
      case (op)
        PUSH: begin
          if (cur_full) begin
            ovf_d = 1'b1;
          end else begin
            wr_en          = 1'b1;
            cnt_d[sel_idx] = cur_cnt + CW'(1);
          end
        end
        POP: begin
          if (cur_empty) begin
            unf_d = 1'b1;
          end else begin
            out_data_d     = rd_data;
            valid_d        = 1'b1;
            cnt_d[sel_idx] = cur_cnt - CW'(1);
          end
        end
        REPLACE: begin
          // An empty stack has no top to swap, so the new value is simply pushed.
          if (cur_empty) begin
            wr_en          = 1'b1;
            cnt_d[sel_idx] = CW'(1);
          end else begin
            out_data_d = rd_data;
            valid_d    = 1'b1;
            wr_en      = 1'b1;
            wr_addr    = rd_addr;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_STACKS; i++) cnt_q[i] <= '0;
      out_data_q <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      bad_q      <= bad_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = valid_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign bad_sel   = bad_q;

  stack_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ENTRIES    (ENTRIES),
    .AW         (AW)
  ) u_mem (
    .clock   (clock),
    .wr_en   (wr_en && !reset),
    .wr_addr (wr_addr),
    .wr_data (inp_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_banked_stack.sv
// Directed, table-driven bench for banked_stack with two 4-deep stacks.
module tb_banked_stack;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int NS    = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [0:0]    stack_sel;
  logic [DW-1:0] inp_data;
  logic          push, pop, flush;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic [NS-1:0] stack_empty, stack_full;
  logic [2:0]    sel_count;
  logic          overflow, underflow, bad_sel;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  banked_stack #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .NUM_STACKS (NS)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .stack_sel   (stack_sel),
    .inp_data    (inp_data),
    .push        (push),
    .pop         (pop),
    .flush       (flush),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .sel_count   (sel_count),
    .overflow    (overflow),
    .underflow   (underflow),
    .bad_sel     (bad_sel)
  );

  typedef struct {
    logic        rst;
    logic        sel;
    logic [31:0] data;
    logic        psh, pp, fl;
    logic [31:0] e_out;
    logic        e_val;
    logic [1:0]  e_emp, e_full;
    logic [2:0]  e_cnt;
    logic        e_ovf, e_unf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic sel, input logic [31:0] data,
                              input logic psh, input logic pp, input logic fl,
                              input logic [31:0] e_out, input logic e_val,
                              input logic [1:0] e_emp, input logic [1:0] e_full,
                              input logic [2:0] e_cnt, input logic e_ovf, input logic e_unf);
    vec_t v;
    v.rst = rst; v.sel = sel; v.data = data; v.psh = psh; v.pp = pp; v.fl = fl;
    v.e_out = e_out; v.e_val = e_val; v.e_emp = e_emp; v.e_full = e_full;
    v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_unf = e_unf;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, let one rising edge pass, then sample 1 ns later.
  task automatic step(input logic rst, input logic sel, input logic [31:0] data,
                      input logic psh, input logic pp, input logic fl);
    @(negedge clock);
    reset     = rst;
    stack_sel = sel;
    inp_data  = data;
    push      = psh;
    pop       = pp;
    flush     = fl;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; stack_sel = '0; inp_data = '0; push = 1'b0; pop = 1'b0; flush = 1'b0;

    //              rst sel data         psh pp fl  out        val emp    full   cnt ovf unf
    vecs.push_back(mk(1, 0, 32'hFF,       1, 0, 0, 32'h0,     0, 2'b11, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'hA,        1, 0, 0, 32'h0,     0, 2'b10, 2'b00, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'hB,        1, 0, 0, 32'h0,     0, 2'b10, 2'b00, 2, 0, 0));
    vecs.push_back(mk(0, 0, 32'hC,        1, 0, 0, 32'h0,     0, 2'b10, 2'b00, 3, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'hC,     1, 2'b10, 2'b00, 2, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'hB,     1, 2'b10, 2'b00, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'hA,     1, 2'b11, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'hA,     0, 2'b11, 2'b00, 0, 0, 1));
    vecs.push_back(mk(0, 1, 32'h11,       1, 0, 0, 32'hA,     0, 2'b01, 2'b00, 1, 0, 0));
    vecs.push_back(mk(0, 1, 32'h12,       1, 0, 0, 32'hA,     0, 2'b01, 2'b00, 2, 0, 0));
    vecs.push_back(mk(0, 1, 32'h13,       1, 0, 0, 32'hA,     0, 2'b01, 2'b00, 3, 0, 0));
    vecs.push_back(mk(0, 1, 32'h14,       1, 0, 0, 32'hA,     0, 2'b01, 2'b10, 4, 0, 0));
    vecs.push_back(mk(0, 1, 32'h15,       1, 0, 0, 32'hA,     0, 2'b01, 2'b10, 4, 1, 0));
    vecs.push_back(mk(0, 1, 32'h0,        0, 1, 0, 32'h14,    1, 2'b01, 2'b00, 3, 0, 0));
    vecs.push_back(mk(0, 0, 32'h1,        1, 0, 0, 32'h14,    0, 2'b00, 2'b00, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h2,        1, 0, 0, 32'h14,    0, 2'b00, 2'b00, 2, 0, 0));
    vecs.push_back(mk(0, 0, 32'h9,        1, 1, 0, 32'h2,     1, 2'b00, 2'b00, 2, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h9,     1, 2'b00, 2'b00, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h1,     1, 2'b01, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h21,       1, 0, 0, 32'h1,     0, 2'b00, 2'b00, 1, 0, 0));
    vecs.push_back(mk(0, 1, 32'h31,       1, 0, 0, 32'h1,     0, 2'b00, 2'b10, 4, 0, 0));
    vecs.push_back(mk(0, 0, 32'h22,       1, 0, 0, 32'h1,     0, 2'b00, 2'b10, 2, 0, 0));
    vecs.push_back(mk(0, 1, 32'h0,        0, 0, 1, 32'h1,     0, 2'b10, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h22,    1, 2'b10, 2'b00, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h21,    1, 2'b11, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h77,       1, 1, 0, 32'h21,    0, 2'b10, 2'b00, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h77,    1, 2'b11, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h55,       1, 0, 0, 32'h77,    0, 2'b10, 2'b00, 1, 0, 0));
    vecs.push_back(mk(0, 1, 32'h66,       1, 0, 0, 32'h77,    0, 2'b00, 2'b00, 1, 0, 0));
    vecs.push_back(mk(1, 0, 32'hEE,       1, 0, 0, 32'h0,     0, 2'b11, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h0,        0, 0, 0, 32'h0,     0, 2'b11, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h3,        1, 1, 1, 32'h0,     0, 2'b11, 2'b00, 0, 0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].sel, vecs[i].data, vecs[i].psh, vecs[i].pp, vecs[i].fl);
      check($sformatf("v%0d out_data", i),    64'(out_data),    64'(vecs[i].e_out));
      check($sformatf("v%0d out_valid", i),   64'(out_valid),   64'(vecs[i].e_val));
      check($sformatf("v%0d stack_empty", i), 64'(stack_empty), 64'(vecs[i].e_emp));
      check($sformatf("v%0d stack_full", i),  64'(stack_full),  64'(vecs[i].e_full));
      check($sformatf("v%0d sel_count", i),   64'(sel_count),   64'(vecs[i].e_cnt));
      check($sformatf("v%0d overflow", i),    64'(overflow),    64'(vecs[i].e_ovf));
      check($sformatf("v%0d underflow", i),   64'(underflow),   64'(vecs[i].e_unf));
      check($sformatf("v%0d bad_sel", i),     64'(bad_sel),     64'(1'b0));
    end

    // out_valid is a single-cycle pulse and out_data holds across idle cycles.
    step(0, 1, 32'h5A, 1, 0, 0);
    step(0, 1, 32'h5B, 1, 0, 0);
    step(0, 1, 32'h0,  0, 1, 0);
    check("seq pop out_data",  64'(out_data),  64'h5B);
    check("seq pop out_valid", 64'(out_valid), 64'h1);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 32'h0, 0, 0, 0);
      check($sformatf("seq idle%0d out_valid", k), 64'(out_valid), 64'h0);
      check($sformatf("seq idle%0d out_data", k),  64'(out_data),  64'h5B);
    end

    // sel_count follows stack_sel combinationally, without a clock edge.
    @(negedge clock);
    stack_sel = 1'b0;
    #1;
    check("seq sel_count s0", 64'(sel_count), 64'h0);
    stack_sel = 1'b1;
    #1;
    check("seq sel_count s1", 64'(sel_count), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
